// File: rtl/output_writeback.sv
// Result writeback stage: turns the output sample stream into addressed memory
// writes through a small FIFO, and tracks sample count, completion and overflow.
module output_writeback #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACTIVATIONS_WIDTH  = 1024,
    parameter int ACTIVATIONS_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FIFO_DEPTH         = 8,
    parameter int ADDR_WIDTH         =
        $clog2(ACTIVATIONS_WIDTH * ACTIVATIONS_HEIGHT * OUTPUT_NB_CHANNELS)
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [IO_DATA_WIDTH-1:0]              out,
    input  logic [$clog2(ACTIVATIONS_WIDTH)-1:0]  output_x,
    input  logic [$clog2(ACTIVATIONS_HEIGHT)-1:0] output_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  output_valid,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [IO_DATA_WIDTH-1:0]              wr_data,
    output logic                                  wr_en,
    input  logic                                  wr_ready,
    output logic [ADDR_WIDTH:0]                   sample_count,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int MW = PW + 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam int EW = ADDR_WIDTH + IO_DATA_WIDTH;
    localparam logic [CW-1:0] NB =
        CW'(ACTIVATIONS_WIDTH * ACTIVATIONS_HEIGHT * OUTPUT_NB_CHANNELS);
    localparam logic [MW-1:0] DEPTH_C = MW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [MW-1:0]       r_mcnt;
    logic                r_wr_en;
    logic [ADDR_WIDTH-1:0]    r_wr_addr;
    logic [IO_DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [CW-1:0]       r_count;
    logic                r_overflow;

    logic                w_valid_in;
    logic                w_pop;
    logic                w_oreg_free;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic                w_mem_empty;
    logic                w_bypass;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [EW-1:0]       w_entry;
    logic [CW-1:0]       w_cnt_inc;

    // Full-precision linear address, wrapped to the memory address width
    assign w_addr = ADDR_WIDTH'(64'(r_base)
                    + (64'(output_y) * 64'(ACTIVATIONS_WIDTH) + 64'(output_x))
                      * 64'(OUTPUT_NB_CHANNELS)
                    + 64'(output_ch));
    assign w_entry     = {w_addr, out};
    assign w_cnt_inc   = r_count + 1'b1;

    assign w_valid_in  = (r_state == S_COLLECT) & output_valid & ~start;
    assign w_pop       = r_wr_en & wr_ready;
    assign w_oreg_free = ~r_wr_en | wr_ready;
    // Occupancy includes the output register
    assign w_full      = (r_mcnt + {{PW{1'b0}}, r_wr_en}) == DEPTH_C;
    assign w_push      = w_valid_in & (~w_full | w_pop);
    assign w_drop      = w_valid_in & ~w_push;
    assign w_mem_empty = (r_mcnt == '0);
    assign w_bypass    = w_push & w_oreg_free & w_mem_empty;
    assign w_mem_rd    = w_oreg_free & ~w_mem_empty;
    assign w_mem_wr    = w_push & ~w_bypass;

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_COLLECT;
        end else begin
            unique case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_COLLECT: begin
                    if (output_valid && (w_cnt_inc == NB)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_mem_empty && !r_wr_en) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mcnt     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_base     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_mcnt     <= '0;
                r_wr_en    <= 1'b0;
                r_base     <= base_addr;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_valid_in) begin
                    r_count <= w_cnt_inc;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_oreg_free) begin
                    if (w_mem_rd) begin
                        {r_wr_addr, r_wr_data} <= r_mem[r_rd_ptr];
                        r_wr_en  <= 1'b1;
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end else if (w_bypass) begin
                        {r_wr_addr, r_wr_data} <= w_entry;
                        r_wr_en <= 1'b1;
                    end else begin
                        r_wr_en <= 1'b0;
                    end
                end
                if (w_mem_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                case ({w_mem_wr, w_mem_rd})
                    2'b10:   r_mcnt <= r_mcnt + 1'b1;
                    2'b01:   r_mcnt <= r_mcnt - 1'b1;
                    default: r_mcnt <= r_mcnt;
                endcase
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign sample_count = r_count;
    assign overflow     = r_overflow;
    assign busy         = (r_state == S_COLLECT) | (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);

endmodule
